// File: rtl/sb_regs_pkg.sv
// Shared types and constants for the sideband register space: FSM states,
// register byte addresses, reset image values and the read-only byte mask.
package sb_regs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SB_DEPTH = 157;

  // Register base byte addresses
  localparam int REG0_ADDR  = 0;
  localparam int REG1_ADDR  = 4;
  localparam int REG5_ADDR  = 8;
  localparam int REG7_ADDR  = 12;
  localparam int REG8_ADDR  = 16;
  localparam int REG9_ADDR  = 20;
  localparam int REG12_ADDR = 78;
  localparam int REG13_ADDR = 81;
  localparam int REG14_ADDR = 85;
  localparam int REG15_ADDR = 89;
  localparam int REG18_ADDR = 93;

  // Link configuration (Gen4) lives in REG12, little-endian bytes 78..80
  localparam int          LINK_CFG_ADDR = REG12_ADDR;
  localparam logic [23:0] LINK_CFG_RST  = 24'h053303;
  localparam logic [31:0] REG14_RST     = 32'hC0C00000;

  // Read-only bytes: 0-7 (REG0/REG1), 78-82 (REG12 + low REG13), 89-92 (REG15)
  localparam logic [SB_DEPTH-1:0] RO_MASK =
      (SB_DEPTH'(8'hFF) << REG0_ADDR) |
      (SB_DEPTH'(5'h1F) << REG12_ADDR) |
      (SB_DEPTH'(4'hF)  << REG15_ADDR);

  // Read-only lookup for a byte address; bytes outside the mask are writable
  function automatic logic is_ro(input int a);
    logic [SB_DEPTH-1:0] m;
    m = RO_MASK >> a;
    return (a >= 0 && a < SB_DEPTH) ? m[0] : 1'b0;
  endfunction

  // Reset image for one byte location
  function automatic logic [7:0] reset_byte(input int a);
    if (a >= LINK_CFG_ADDR && a < LINK_CFG_ADDR + 3)
      return 8'(LINK_CFG_RST >> (8 * (a - LINK_CFG_ADDR)));
    else if (a >= REG14_ADDR && a < REG14_ADDR + 4)
      return 8'(REG14_RST >> (8 * (a - REG14_ADDR)));
    else
      return 8'h00;
  endfunction

endpackage

// File: rtl/sb_regfile_mem.sv
// Byte array holding the sideband registers: reset image, one combinational
// read port, a transaction write port that honours the read-only mask and a
// hardware update port that may write any byte and wins on collision.
module sb_regfile_mem
  import sb_regs_pkg::*;
#(
  parameter int DEPTH  = 157,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [7:0]        rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              ro_hit,
  input  logic              hw_we,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [7:0]        hw_wdata
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [7:0] mem [DEPTH];
  logic       wr_in_range;
  logic       hw_in_range;

  assign ro_hit      = is_ro(int'(wr_addr));
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign hw_in_range = {1'b0, hw_addr} < DEPTH_W;
  assign rd_data     = (rd_addr < DEPTH_W) ? mem[rd_addr[ADDR_W-1:0]] : 8'h00;

  // Byte storage: reset image, transaction write, then hardware write last so it wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= reset_byte(i);
    end else begin
      if (wr_en && !ro_hit && wr_in_range) mem[wr_addr] <= wr_data;
      if (hw_we && hw_in_range)            mem[hw_addr] <= hw_wdata;
    end
  end

endmodule

// File: rtl/sb_register_file.sv
// Sideband register file: accepts AT read/write burst requests, streams read
// bytes with valid/ready, consumes write bytes, flags range/length/read-only
// errors on a one-cycle done pulse and exposes a hardware update port.
module sb_register_file
  import sb_regs_pkg::*;
#(
  parameter int DEPTH   = 157,
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 7,
  parameter int MAX_LEN = 64
) (
  input  logic              fsm_clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_last,
  output logic              done,
  output logic              done_err,
  input  logic              hw_we,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [7:0]        hw_wdata
);

  localparam logic [ADDR_W:0]  DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  ADDR_ONE  = (ADDR_W + 1)'(1);
  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO  = '0;

  state_t            state_q, state_d;
  logic              alive_q;
  logic              err_q;
  logic              ro_err_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [ADDR_W:0]   addr_q;
  logic [7:0]        rsp_q;

  logic              accept;
  logic              rd_beat;
  logic              wr_beat;
  logic              last_beat;
  logic              req_err;
  logic              ro_hit;
  logic [ADDR_W:0]   req_end;
  logic [ADDR_W:0]   rd_addr;
  logic [7:0]        rd_data;

  // Handshakes and outputs are decoded from registered state only
  assign req_ready = alive_q && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RD);
  assign wr_ready  = (state_q == WR);
  assign rd_beat   = rsp_valid && rsp_ready;
  assign wr_beat   = wr_ready && wr_valid;
  assign last_beat = (cnt_q == LEN_ONE);
  assign rsp_last  = rsp_valid && last_beat;
  assign rsp_data  = rsp_valid ? rsp_q : 8'h00;
  assign done      = (state_q == DONE);
  assign done_err  = done && (err_q || ro_err_q);

  // End address evaluated one bit wider than the address so it cannot wrap
  assign req_end = {1'b0, req_addr} + (ADDR_W + 1)'(req_len);
  assign req_err = (req_len == LEN_ZERO) || (req_len > MAX_LEN_W) || (req_end > DEPTH_W);

  // Look ahead: fetch the first byte at accept, the next byte on each read handshake
  assign rd_addr = (state_q == IDLE) ? {1'b0, req_addr} : addr_q + ADDR_ONE;

  sb_regfile_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk      (fsm_clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_beat && !err_q),
    .wr_addr  (addr_q[ADDR_W-1:0]),
    .wr_data  (wr_data),
    .ro_hit   (ro_hit),
    .hw_we    (hw_we),
    .hw_addr  (hw_addr),
    .hw_wdata (hw_wdata)
  );

  // Next-state selection for the transaction FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (req_len == LEN_ZERO) state_d = DONE;
        else if (req_write)      state_d = WR;
        else                     state_d = RD;
      end
      RD:   if (rd_beat && last_beat) state_d = DONE;
      WR:   if (wr_beat && last_beat) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, ready gate, error flags and remaining byte count
  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      alive_q  <= 1'b0;
      err_q    <= 1'b0;
      ro_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (accept) begin
        err_q    <= req_err;
        ro_err_q <= 1'b0;
        cnt_q    <= req_len;
      end else if (rd_beat || wr_beat) begin
        cnt_q <= cnt_q - LEN_ONE;
        if (wr_beat && !err_q && ro_hit) ro_err_q <= 1'b1;
      end
    end
  end

  // Datapath registers: current byte address and the held read beat
  always_ff @(posedge fsm_clk) begin
    if (accept) begin
      addr_q <= {1'b0, req_addr};
      rsp_q  <= req_err ? 8'h00 : rd_data;
    end else if (rd_beat || wr_beat) begin
      addr_q <= addr_q + ADDR_ONE;
      rsp_q  <= err_q ? 8'h00 : rd_data;
    end
  end

endmodule

// File: tb/tb_sb_register_file.sv
// Randomised and directed bench for sb_register_file against a byte-array
// reference model of the register space.
module tb_sb_register_file;

  localparam int DEPTH   = 157;
  localparam int MAX_LEN = 64;

  logic       fsm_clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr;
  logic [6:0] req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rsp_valid, rsp_ready, rsp_last;
  logic [7:0] rsp_data;
  logic       done, done_err;
  logic       hw_we;
  logic [7:0] hw_addr, hw_wdata;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mdl  [DEPTH];
  logic [7:0] wbuf [128];

  always #5 fsm_clk = ~fsm_clk;

  sb_register_file dut (
    .fsm_clk   (fsm_clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .done      (done),
    .done_err  (done_err),
    .hw_we     (hw_we),
    .hw_addr   (hw_addr),
    .hw_wdata  (hw_wdata)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ro_ref(input int a);
    return (a >= 0 && a <= 7) || (a >= 78 && a <= 82) || (a >= 89 && a <= 92);
  endfunction

  function automatic bit err_ref(input int a, input int l);
    return (l == 0) || (l > MAX_LEN) || (a + l > DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    mdl[78] = 8'h03; mdl[79] = 8'h33; mdl[80] = 8'h05;
    mdl[87] = 8'hC0; mdl[88] = 8'hC0;
  endtask

  // Read burst; optional random back-pressure plus a forced stall of stall_n cycles on beat stall_beat
  task automatic do_read(input int a, input int l, input int stall_pct,
                         input int stall_beat, input int stall_n);
    int beats, cyc, stalled;
    bit err, seen;
    logic [7:0] exp;
    err = err_ref(a, l);
    check("rd_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'(a); req_len = 7'(l);
    @(negedge fsm_clk);
    req_valid = 1'b0;
    check("rd_first", {done, rsp_valid}, (l == 0) ? 2'b10 : 2'b01);
    beats = 0; cyc = 0; stalled = 0; seen = 0;
    while (!seen && cyc < 1000) begin
      if (done) begin
        seen = 1;
        check("rd_beats", beats, l);
        check("rd_done_err", done_err, err);
      end else begin
        if (rsp_valid) begin
          exp = (err || a + beats >= DEPTH || beats >= l) ? 8'h00 : mdl[a + beats];
          check("rd_data", rsp_data, exp);
          check("rd_last", rsp_last, (beats == l - 1));
          if (beats == stall_beat && stalled < stall_n) begin
            rsp_ready = 1'b0;
            stalled++;
          end else begin
            rsp_ready = ($urandom_range(99) >= stall_pct);
          end
          if (rsp_ready) beats++;
        end else begin
          rsp_ready = 1'b0;
        end
        @(negedge fsm_clk);
        cyc++;
      end
    end
    rsp_ready = 1'b0;
    if (!seen) check("rd_timeout", 0, 1);
    @(negedge fsm_clk);
    check("rd_post_done", {done, req_ready}, 2'b01);
  endtask

  // Write burst from wbuf; optional hardware write issued alongside beat hw_beat
  task automatic do_write(input int a, input int l, input int gap_pct,
                          input int hw_beat, input int hw_a, input logic [7:0] hw_d);
    int beats, cyc;
    bit err, roe, seen, v;
    err = err_ref(a, l);
    roe = 0;
    check("wr_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'(a); req_len = 7'(l);
    @(negedge fsm_clk);
    req_valid = 1'b0;
    check("wr_first", {done, wr_ready}, (l == 0) ? 2'b10 : 2'b01);
    beats = 0; cyc = 0; seen = 0;
    while (!seen && cyc < 1000) begin
      if (done) begin
        seen = 1;
        check("wr_beats", beats, l);
        check("wr_done_err", done_err, err || roe);
      end else begin
        v = ($urandom_range(99) >= gap_pct) && (beats < l);
        wr_valid = v;
        wr_data  = wbuf[beats & 127];
        hw_we    = 1'b0;
        if (v) begin
          if (!err) begin
            if (ro_ref(a + beats)) roe = 1;
            else mdl[a + beats] = wbuf[beats];
          end
          if (beats == hw_beat) begin
            hw_we = 1'b1; hw_addr = 8'(hw_a); hw_wdata = hw_d;
            if (hw_a < DEPTH) mdl[hw_a] = hw_d;
          end
          beats++;
        end
        @(negedge fsm_clk);
        cyc++;
      end
    end
    wr_valid = 1'b0;
    hw_we    = 1'b0;
    if (!seen) check("wr_timeout", 0, 1);
    @(negedge fsm_clk);
    check("wr_post_done", {done, req_ready}, 2'b01);
  endtask

  task automatic hw_idle(input int a, input logic [7:0] d);
    hw_we = 1'b1; hw_addr = 8'(a); hw_wdata = d;
    if (a < DEPTH) mdl[a] = d;
    @(negedge fsm_clk);
    hw_we = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, l;
    rst = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
    wr_valid = 0; wr_data = 0; rsp_ready = 0;
    hw_we = 0; hw_addr = 0; hw_wdata = 0;
    model_reset();
    repeat (3) @(negedge fsm_clk);
    check("rst_outputs", {req_ready, wr_ready, rsp_valid, rsp_last, done, done_err, rsp_data}, 0);
    rst = 1'b1;
    @(negedge fsm_clk);
    check("rst_release_ready", req_ready, 1);

    // Link configuration readback
    do_read(78, 3, 0, -1, 0);

    // Write then read REG14 bytes
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    do_write(85, 2, 0, -1, 0, 8'h00);
    do_read(85, 4, 0, -1, 0);

    // Read-only bytes drop writes and flag the transaction
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(80, 3, 0, -1, 0, 8'h00);
    do_read(80, 3, 0, -1, 0);

    // Range, zero-length and over-length errors
    do_read(150, 10, 0, -1, 0);
    do_read(5, 0, 0, -1, 0);
    do_read(0, 65, 0, -1, 0);
    do_read(0, 64, 20, -1, 0);

    // Back-pressure on the second beat
    do_read(78, 3, 0, 1, 3);

    // Hardware write colliding with transaction beats (RO and writable targets)
    wbuf[0] = 8'h77;
    do_write(79, 1, 0, 0, 79, 8'h44);
    wbuf[0] = 8'h12;
    do_write(85, 1, 0, 0, 85, 8'h34);
    do_read(78, 10, 0, -1, 0);
    hw_idle(200, 8'h99);
    hw_idle(3, 8'h5A);
    do_read(0, 8, 0, -1, 0);

    // Reset in the middle of a read burst
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd78; req_len = 7'd3;
    @(negedge fsm_clk);
    req_valid = 1'b0;
    check("mid_burst_valid", rsp_valid, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_outputs", {rsp_valid, done, req_ready}, 0);
    model_reset();
    repeat (2) @(negedge fsm_clk);
    check("mid_rst_no_done", done, 0);
    rst = 1'b1;
    @(negedge fsm_clk);
    check("mid_rst_release", {req_ready, done}, 2'b10);
    do_read(78, 3, 0, -1, 0);

    // Randomised mix of transactions and idle hardware updates
    for (int t = 0; t < 60; t++) begin
      a = $urandom_range(0, 160);
      l = ($urandom_range(1) == 1) ? $urandom_range(1, 8) : $urandom_range(0, 70);
      case ($urandom_range(2))
        0: do_read(a, l, 30, -1, 0);
        1: begin
          for (int i = 0; i < 128; i++) wbuf[i] = 8'($urandom);
          do_write(a, l, 30, -1, 0, 8'h00);
        end
        default: hw_idle($urandom_range(0, 200), 8'($urandom));
      endcase
    end
    do_read(0, 64, 0, -1, 0);
    do_read(64, 64, 0, -1, 0);
    do_read(128, 29, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sb_register_file.md
Name: sb_register_file

Overview:
Parametrised sideband register space serving AT read and AT write transactions with multi-byte bursts, replacing the fixed 3-byte read path.
- Sits between the sideband transaction decoder (request side) and the AT response builder (read-data side).
- Adds per-byte read-only protection, range/length error reporting, valid/ready flow control and a hardware update port for the logical-layer FSMs.

Parameters:
- DEPTH, 157, number of byte locations
- ADDR_W, 8, byte address width
- LEN_W, 7, burst length field width (bytes)
- MAX_LEN, 64, largest legal burst

Ports:
- fsm_clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  transaction request
- req_ready  out  1  block idle, request accepted when req_valid&&req_ready
- req_write  in  1  1=AT write, 0=AT read
- req_addr  in  ADDR_W  start byte address
- req_len  in  LEN_W  byte count
- wr_valid  in  1  write data beat valid
- wr_ready  out  1  write beat accepted
- wr_data  in  8  write byte
- rsp_valid  out  1  read data beat valid
- rsp_ready  in  1  downstream accepts beat
- rsp_data  out  8  read byte
- rsp_last  out  1  final read beat
- done  out  1  one-cycle completion pulse
- done_err  out  1  qualifies done: range, length or read-only error
- hw_we  in  1  hardware update strobe
- hw_addr  in  ADDR_W  hardware update address
- hw_wdata  in  8  hardware update byte

Behaviour:
- Reset (async, rst=0):
  - All outputs 0, except req_ready=1 one cycle after reset release.
  - FSM enters IDLE.
  - Memory bytes 78/79/80 = 03/33/05 (link configuration, Gen4).
  - Bytes 85/86/87/88 = 00/00/C0/C0.
  - All other bytes 00.
  - Reset mid-burst aborts the transaction with no done pulse.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - req_ready=1.
  - On accept, latch addr, len and write flag.
  - Error check: err = (len==0) || (len>MAX_LEN) || (addr+len > DEPTH), computed at ADDR_W+1 bits, no wrap.
  - len==0 goes directly to DONE with err.
  - Otherwise go to RD or WR with a byte counter initialised to len.
- RD:
  - First beat is valid the cycle after accept.
  - rsp_data = mem[addr+i], or 00 if err.
  - Advance on rsp_valid&&rsp_ready; rsp_data/rsp_valid are held stable while stalled.
  - rsp_last=1 on beat len-1.
  - After the last handshake go to DONE.
- WR:
  - wr_ready=1; one byte consumed per wr_valid.
  - Byte i is written to addr+i unless err or the RO bit is set.
  - A write to an RO byte is dropped and sets a sticky ro_err for the transaction.
  - After len beats go to DONE.
- RO bytes: 0-7, 78-82, 89-92 (package constant, a DEPTH-bit mask).
- DONE:
  - done=1 for one cycle; done_err = err || ro_err.
  - Return to IDLE, where req_ready reasserts the following cycle.
- Hardware port: hw_we writes any byte, RO included, at any state.
  - Same-cycle collision with a WR beat at the same address: hw_wdata wins.
  - A read beat launched in the same cycle returns the pre-update value.
- hw_addr >= DEPTH: ignored.
- wr_valid outside WR and rsp_ready outside RD are ignored.

Decomposition:
- Package sb_regs_pkg:
  - State enum.
  - Reset constants: LINK_CFG_ADDR=78, LINK_CFG_RST=24'h053303, REG14_ADDR=85, REG14_RST=32'hC0C00000.
  - RO_MASK.
  - Register address constants for REG0, REG1, REG5, REG7, REG8, REG9, REG12, REG13, REG14, REG15, REG18.
- One sub-module, sb_regfile_mem: byte array with reset image, one read port, two write ports (hw priority) and the RO mask lookup.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then read addr 78 len 3, rsp_ready=1 -> beats 03,33,05 on consecutive cycles, rsp_last on 05, done=1 with done_err=0.
- Write addr 85 len 2 data AA,BB, then read 85 len 4 -> AA,BB,C0,C0, done_err=0 on both transactions.
- Write addr 80 len 3 data 11,22,33 -> done_err=1; read 80 len 3 -> 05,00,00 (80 RO; 81 RO and 82 RO both keep reset 00).
- Read addr 150 len 10 -> ten 00 beats, done_err=1. Read len 0 -> no beats, done=1, done_err=1, one cycle after accept.
- Read addr 78 len 3 with rsp_ready low 3 cycles on beat 2 -> rsp_data holds 33 while stalled, total beats exactly 3.
- hw_we addr 79 data 44 during a WR burst writing 79 -> mem[79]=44 afterwards. Assert rst mid-burst -> rsp_valid=0, no done, mem[78]=03.
